// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch -- instruction fetch stage between the PC register and decode.
//
// Accepts fetch addresses from the PC register, issues one word read at a
// time on a req/ack instruction-memory port, and buffers returned words in an
// in-order FIFO that presents {pc, inst} to decode with valid/ready.
// Every outstanding request owns a FIFO slot before it is issued, so the FIFO
// can never overflow. flush_i discards the FIFO and the outstanding request.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   pc_i, ce_i    fetch address and its valid from the PC register
//   pc_stall_o    1 = pc_i not taken this cycle, PC register must hold
//   flush_i       redirect: empty FIFO, kill outstanding request
//   imem_req_o    memory read request (held until imem_ack_i)
//   imem_addr_o   memory read address (stable while imem_req_o=1)
//   imem_ack_i    read done, imem_rdata_i valid
//   imem_rdata_i  read data
//   id_valid_o    FIFO head valid to decode
//   id_ready_i    decode takes the head
//   id_pc_o       head PC
//   id_inst_o     head instruction
//   id_exc_o      head misaligned-fetch flag (only with IF_MISALIGN_EXC_EN)
//
// Build option
//   IF_MISALIGN_EXC_EN  when defined, a misaligned pc_i issues no memory read
//                       and instead queues a NOP (32'h00000013) flagged on
//                       id_exc_o. When undefined, imem_addr_o[1:0] is forced
//                       to 2'b00 and misalignment is silently truncated.
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter int ADDR_W     = 32,
    parameter int INST_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    output logic              pc_stall_o,
    input  logic              flush_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic              id_valid_o,
    input  logic              id_ready_i,
    output logic [ADDR_W-1:0] id_pc_o,
`ifdef IF_MISALIGN_EXC_EN
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_exc_o
`else
    output logic [INST_W-1:0] id_inst_o
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,   // no request outstanding
        S_REQ,    // request outstanding, data will be kept
        S_DRAIN   // request outstanding after a flush, data will be dropped
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
    logic [INST_W-1:0] fifo_inst [FIFO_DEPTH];

    logic              ack_in_req;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              state_ok;
    logic              slot_ok;
    logic              accept;
    logic              fetch;
    logic [CW:0]       occ_next;
    logic [INST_W-1:0] push_inst;

`ifdef IF_MISALIGN_EXC_EN
    localparam logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013);
    logic              exc_pend_q;
    logic              misaligned;
    logic              fifo_exc [FIFO_DEPTH];
`endif

    // -----------------------------------------------------------------------
    // Handshake decode and PC back-pressure
    // -----------------------------------------------------------------------
    assign ack_in_req = (state_q == S_REQ) && imem_ack_i;
    assign pop        = id_valid_o && id_ready_i;

`ifdef IF_MISALIGN_EXC_EN
    // A pending misaligned entry is pushed in a cycle where the FSM is idle,
    // so it never coincides with a memory push.
    assign push       = ack_in_req || exc_pend_q;
    assign push_inst  = exc_pend_q ? NOP_INST : imem_rdata_i;
    assign misaligned = accept && (pc_i[1:0] != 2'b00);
    assign fetch      = accept && !misaligned;
`else
    assign push       = ack_in_req;
    assign push_inst  = imem_rdata_i;
    assign fetch      = accept;
`endif

    // Occupancy after this cycle's push/pop; a new request is only taken if
    // that still leaves a slot for its eventual data.
    assign occ_next   = {1'b0, count_q} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
    assign slot_ok    = occ_next < (CW+1)'(FIFO_DEPTH);
    assign state_ok   = (state_q == S_IDLE) || ack_in_req;
    assign pc_stall_o = flush_i || !state_ok || !slot_ok;
    assign accept     = ce_i && !pc_stall_o && !flush_i;
    assign wr_en      = push && !flush_i;

    // -----------------------------------------------------------------------
    // FSM next state
    // -----------------------------------------------------------------------
    // NOTE: every signal driven in an always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (fetch) state_d = S_REQ;
            end
            S_REQ: begin
                if (flush_i)         state_d = imem_ack_i ? S_IDLE : S_DRAIN;
                else if (imem_ack_i) state_d = fetch ? S_REQ : S_IDLE;
            end
            S_DRAIN: begin
                if (imem_ack_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State, request address and FIFO control
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
`ifdef IF_MISALIGN_EXC_EN
                addr_q <= pc_i;
`else
                addr_q <= pc_i & ~ADDR_W'(3);
`endif
            end
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)   rd_ptr_q <= rd_ptr_q + PW'(1);
                count_q <= count_q + CW'(push) - CW'(pop);
            end
        end
    end

`ifdef IF_MISALIGN_EXC_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) exc_pend_q <= 1'b0;
        else      exc_pend_q <= misaligned;
    end
`endif

    // NOTE: FIFO storage is deliberately not reset; an entry is only ever
    // observed through the valid-gated outputs below, after it was written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_pc[wr_ptr_q]   <= addr_q;
            fifo_inst[wr_ptr_q] <= push_inst;
`ifdef IF_MISALIGN_EXC_EN
            fifo_exc[wr_ptr_q]  <= exc_pend_q;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign imem_req_o  = (state_q != S_IDLE);
    assign imem_addr_o = addr_q;
    assign id_valid_o  = (count_q != '0);
    assign id_pc_o     = id_valid_o ? fifo_pc[rd_ptr_q]   : '0;
    assign id_inst_o   = id_valid_o ? fifo_inst[rd_ptr_q] : '0;
`ifdef IF_MISALIGN_EXC_EN
    assign id_exc_o    = id_valid_o && fifo_exc[rd_ptr_q];
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch -- self-checking bench for inst_fetch.
//
// A transaction-level model (outstanding request + queue of expected
// {pc, inst, exc} entries) predicts the DUT outputs every cycle; a compare
// process on the falling edge checks them. Directed scenarios drive the
// inputs just after the rising edge and add literal checks that pin the
// model. Memory returns mem_word(addr) = addr + 32'h1000_0000 after a
// programmable number of wait cycles.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_i;
    logic          ce_i;
    logic          pc_stall_o;
    logic          flush_i;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_ack_i;
    logic [IW-1:0] imem_rdata_i;
    logic          id_valid_o;
    logic          id_ready_i;
    logic [AW-1:0] id_pc_o;
    logic [IW-1:0] id_inst_o;
`ifdef IF_MISALIGN_EXC_EN
    logic          id_exc_o;
`endif

    inst_fetch #(.ADDR_W(AW), .INST_W(IW), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .pc_stall_o   (pc_stall_o),
        .flush_i      (flush_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .id_valid_o   (id_valid_o),
        .id_ready_i   (id_ready_i),
        .id_pc_o      (id_pc_o),
`ifdef IF_MISALIGN_EXC_EN
        .id_inst_o    (id_inst_o),
        .id_exc_o     (id_exc_o)
`else
        .id_inst_o    (id_inst_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1000_0000;
    endfunction

    // Stimulus controls
    int   lat        = 0;   // memory wait cycles before ack
    bit   force_data = 0;   // return 32'hDEADBEEF instead of mem_word()
    int   wait_cnt   = 0;   // cycles the current request has been waiting
    bit   acc_seen   = 0;   // PC register saw pc_i taken in the last cycle

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } entry_t;

    entry_t      m_q[$];
    bit          m_busy;      // a memory request is outstanding
    bit          m_kill;      // its data must be discarded
    logic [31:0] m_addr;
    bit          m_exc_pend;  // misaligned entry to push next cycle
    logic [31:0] m_exc_pc;

    initial begin
        entry_t e;
        bit     exp_valid, ok_state, push, pop, exp_stall, acc, ackd;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_q.delete();
                m_busy = 0; m_kill = 0; m_addr = '0;
                m_exc_pend = 0; m_exc_pc = '0;
                wait_cnt = 0; acc_seen = 0;
            end else begin
                exp_valid = (m_q.size() != 0);
                check("req",   imem_req_o, m_busy);
                if (m_busy) check("addr", imem_addr_o, m_addr);
                check("valid", id_valid_o, exp_valid);
                check("id_pc",   id_pc_o,   exp_valid ? m_q[0].pc   : 32'h0);
                check("id_inst", id_inst_o, exp_valid ? m_q[0].inst : 32'h0);
`ifdef IF_MISALIGN_EXC_EN
                check("id_exc",  id_exc_o,  exp_valid ? m_q[0].exc  : 1'b0);
`endif
                ackd      = m_busy && imem_ack_i;
                ok_state  = !m_busy || (ackd && !m_kill);
                push      = (ackd && !m_kill) || m_exc_pend;
                pop       = exp_valid && id_ready_i;
                exp_stall = flush_i || !ok_state ||
                            (m_q.size() + int'(push) - int'(pop) >= DEPTH);
                check("stall", pc_stall_o, exp_stall);
                acc      = ce_i && !exp_stall && !flush_i;
                acc_seen = ce_i && !pc_stall_o && !flush_i;

                if (flush_i) begin
                    m_q.delete();
                    m_exc_pend = 0;
                    if (ackd)        begin m_busy = 0; m_kill = 0; end
                    else if (m_busy) m_kill = 1;
                end else begin
                    if (pop) void'(m_q.pop_front());
                    if (m_exc_pend) begin
                        e.pc = m_exc_pc; e.inst = 32'h0000_0013; e.exc = 1'b1;
                        m_q.push_back(e);
                        m_exc_pend = 0;
                    end
                    if (ackd) begin
                        if (!m_kill) begin
                            e.pc = m_addr; e.inst = imem_rdata_i; e.exc = 1'b0;
                            m_q.push_back(e);
                        end
                        m_busy = 0; m_kill = 0;
                    end
                    if (acc) begin
`ifdef IF_MISALIGN_EXC_EN
                        if (pc_i[1:0] != 2'b00) begin
                            m_exc_pend = 1; m_exc_pc = pc_i;
                        end else begin
                            m_busy = 1; m_addr = pc_i;
                        end
`else
                        m_busy = 1; m_addr = {pc_i[31:2], 2'b00};
`endif
                    end
                end

                if (imem_req_o && imem_ack_i) wait_cnt = 0;
                else if (imem_req_o)          wait_cnt++;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Driver: PC register + memory responder, one call per clock cycle
    // -----------------------------------------------------------------------
    task automatic cycle(input logic ce_v, input logic rdy_v, input logic fl_v,
                         input logic ld = 1'b0, input logic [31:0] ld_pc = 32'h0);
        @(posedge clk);
        #1;
        if (ld)            pc_i = ld_pc;
        else if (acc_seen) pc_i = pc_i + 32'd4;
        ce_i         = ce_v;
        id_ready_i   = rdy_v;
        flush_i      = fl_v;
        imem_ack_i   = imem_req_o && (wait_cnt >= lat);
        imem_rdata_i = force_data ? 32'hDEADBEEF : mem_word(imem_addr_o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; pc_i = '0; ce_i = 0; flush_i = 0;
        imem_ack_i = 0; imem_rdata_i = '0; id_ready_i = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst req",   imem_req_o,  1'b0);
        check("rst addr",  imem_addr_o, 32'h0);
        check("rst valid", id_valid_o,  1'b0);
        check("rst pc",    id_pc_o,     32'h0);
        check("rst inst",  id_inst_o,   32'h0);
        @(negedge clk); #1 rst = 1'b1;

        // 1: zero-wait memory, one instruction per cycle
        lat = 0;
        cycle(1, 1, 0, 1, 32'h0);
        cycle(1, 1, 0);
        #1 check("t1 req", imem_req_o, 1'b1);
        check("t1 addr", imem_addr_o, 32'h0);
        cycle(1, 1, 0);
        #1 check("t1 valid", id_valid_o, 1'b1);
        check("t1 pc0",   id_pc_o,   32'h0);
        check("t1 inst0", id_inst_o, 32'h1000_0000);
        cycle(1, 1, 0);
        #1 check("t1 pc1", id_pc_o,   32'h4);
        check("t1 inst1",  id_inst_o, 32'h1000_0004);
        cycle(1, 1, 0);
        #1 check("t1 pc2", id_pc_o, 32'h8);
        repeat (3) cycle(1, 1, 0);
        idle(6);

        // 2: three wait cycles, address stable and PC stalled while waiting
        lat = 3;
        cycle(1, 1, 0, 1, 32'h40);
        for (int w = 0; w < 3; w++) begin
            cycle(1, 1, 0);
            #1 check("t2 wait addr",  imem_addr_o, 32'h40);
            check("t2 wait stall", pc_stall_o, 1'b1);
        end
        cycle(1, 1, 0);
        #1 check("t2 ack stall", pc_stall_o, 1'b0);
        repeat (12) cycle(1, 1, 0);
        idle(8);

        // 3: decode stalled, FIFO fills to depth and fetch stops
        lat = 0;
        cycle(1, 0, 0, 1, 32'h80);
        repeat (10) cycle(1, 0, 0);
        #1 check("t3 full valid", id_valid_o, 1'b1);
        check("t3 full head",  id_pc_o,    32'h80);
        check("t3 full stall", pc_stall_o, 1'b1);
        check("t3 full noreq", imem_req_o, 1'b0);
        cycle(1, 1, 0);
        #1 check("t3 drain0", id_pc_o, 32'h80);
        cycle(1, 1, 0);
        #1 check("t3 drain1", id_pc_o, 32'h84);
        repeat (6) cycle(1, 1, 0);
        idle(6);

        // 4a: flush of a full FIFO empties it for the next cycle
        cycle(1, 0, 0, 1, 32'h300);
        repeat (3) cycle(1, 0, 0);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        #1 check("t4 flushed valid", id_valid_o, 1'b0);
        idle(3);

        // 4b: flush during a pending request, late data discarded
        lat = 3; force_data = 1;
        cycle(1, 1, 0, 1, 32'h100);
        cycle(0, 1, 0);
        cycle(0, 1, 1);
        #1 check("t4 flush stall", pc_stall_o, 1'b1);
        cycle(0, 1, 0);
        #1 check("t4 drain req", imem_req_o, 1'b1);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        #1 check("t4 dropped", id_valid_o, 1'b0);
        check("t4 req done", imem_req_o, 1'b0);
        force_data = 0; lat = 0;
        cycle(1, 1, 0, 1, 32'h200);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        #1 check("t4 refetch pc",   id_pc_o,   32'h200);
        check("t4 refetch inst", id_inst_o, 32'h1000_0200);
        idle(4);

        // 5: asynchronous reset with a request outstanding and a full entry
        cycle(1, 0, 0, 1, 32'h400);
        cycle(0, 0, 0);
        lat = 3;
        cycle(1, 0, 0, 1, 32'h500);
        cycle(0, 0, 0);
        #1 check("t5 pre req", imem_req_o, 1'b1);
        #1 rst = 1'b0;
        #1 check("t5 async req",   imem_req_o,  1'b0);
        check("t5 async valid", id_valid_o,  1'b0);
        check("t5 async addr",  imem_addr_o, 32'h0);
        check("t5 async pc",    id_pc_o,     32'h0);
        check("t5 async inst",  id_inst_o,   32'h0);
        @(negedge clk); #1 imem_ack_i = 1'b1; imem_rdata_i = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("t5 ack in rst", id_valid_o, 1'b0);
        imem_ack_i = 1'b0;
        @(negedge clk); #1 rst = 1'b1;
        lat = 0;
        cycle(1, 1, 0, 1, 32'h0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);
        #1 check("t5 post pc",   id_pc_o,   32'h0);
        check("t5 post inst", id_inst_o, 32'h1000_0000);
        idle(4);

`ifdef IF_MISALIGN_EXC_EN
        // 6: misaligned fetch turns into a flagged NOP without a memory read
        cycle(1, 1, 0, 1, 32'h6);
        cycle(0, 1, 0);
        #1 check("t6 noreq", imem_req_o, 1'b0);
        cycle(0, 1, 0);
        #1 check("t6 pc",   id_pc_o,   32'h6);
        check("t6 inst", id_inst_o, 32'h0000_0013);
        check("t6 exc",  id_exc_o,  1'b1);
        idle(4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
